ram_port_arbiter: RTL and testbench

- Sequences the single asynchronous SRAM (RAM2) shared by the CPU's instruction-fetch port (IF) and data-memory port (MEM).
- Generates the SRAM chip-enable, output-enable and write-enable strobes, and drives the tri-state data bus.
- Sits between the pipeline and the address-decode/MMIO layer.
- Arbitrates with MEM priority. Requests to the serial MMIO window BF00–BF03 are acknowledged without touching the SRAM.

---
 rtl/ram_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Shares one async SRAM between IF and MEM ports, MEM priority; MMIO window BF00+ acked without SRAM access.
// Latency grant->ready: read 3, write 4, MMIO 1. Requesters hold req until their one-cycle ready pulse.
// `define IF_STARVE_GUARD_EN forces an IF grant after STARVE_LIMIT consecutive MEM grants.
module ram_port_arbiter #(
    parameter logic [15:0] IO_BASE      = 16'hBF00,
    parameter int          IO_SIZE      = 4,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    output logic        busy,
    output logic [15:0] ram2_addr,
    inout  wire  [15:0] ram2_data,
    output logic        ram2_en_n,
    output logic        ram2_oe_n,
    output logic        ram2_we_n
);

    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD
    } state_t;

    localparam logic [16:0] IO_END = {1'b0, IO_BASE} + 17'(IO_SIZE);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        owner_mem_q, owner_mem_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic        busy_q, busy_d;
    logic        en_n_q, en_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        drive_q, drive_d;

    logic if_ok, mem_ok, mem_is_io, force_if, grant_mem, grant_if;

`ifdef IF_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_q, starve_d;
`endif

    always_comb begin
        // A port whose ready is high this cycle is still holding its old req.
        if_ok     = if_req  && !if_ready_q;
        mem_ok    = mem_req && !mem_ready_q;
        mem_is_io = (mem_addr >= IO_BASE) && ({1'b0, mem_addr} < IO_END);
`ifdef IF_STARVE_GUARD_EN
        force_if  = if_ok && (starve_q == CNT_W'(STARVE_LIMIT));
`else
        force_if  = 1'b0;
`endif
        grant_mem = (state_q == IDLE) && mem_ok && !force_if;
        grant_if  = (state_q == IDLE) && if_ok && !grant_mem;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_mem_d = owner_mem_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    if (mem_is_io) begin
                        mem_ready_d = 1'b1;
                    end else begin
                        addr_d      = mem_addr;
                        owner_mem_d = 1'b1;
                        if (mem_we) begin
                            wdata_d = mem_wdata;
                            state_d = WR_SETUP;
                        end else begin
                            state_d = RD_SETUP;
                        end
                    end
                end else if (grant_if) begin
                    addr_d      = if_addr;
                    owner_mem_d = 1'b0;
                    state_d     = RD_SETUP;
                end
            end
            RD_SETUP:  state_d = RD_SAMPLE;
            RD_SAMPLE: begin
                state_d = IDLE;
                if (owner_mem_q) begin
                    mem_rdata_d = ram2_data;
                    mem_ready_d = 1'b1;
                end else begin
                    if_rdata_d  = ram2_data;
                    if_ready_d  = 1'b1;
                end
            end
            WR_SETUP:  state_d = WR_PULSE;
            WR_PULSE:  state_d = WR_HOLD;
            WR_HOLD: begin
                state_d     = IDLE;
                mem_ready_d = 1'b1;
            end
            default:   state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they line up with it.
        en_n_d  = (state_d == IDLE);
        oe_n_d  = !((state_d == RD_SETUP) || (state_d == RD_SAMPLE));
        we_n_d  = (state_d != WR_PULSE);
        drive_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
        busy_d  = (state_d != IDLE);
    end

`ifdef IF_STARVE_GUARD_EN
    always_comb begin
        starve_d = starve_q;
        if (!if_req || grant_if) begin
            starve_d = '0;
        end else if (grant_mem && (starve_q != CNT_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_mem_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            en_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_mem_q <= owner_mem_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            busy_q      <= busy_d;
            en_n_q      <= en_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            drive_q     <= drive_d;
        end
    end

    assign ram2_data = drive_q ? wdata_q : 16'hzzzz;
    assign ram2_addr = addr_q;
    assign ram2_en_n = en_n_q;
    assign ram2_oe_n = oe_n_q;
    assign ram2_we_n = we_n_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ready  = if_ready_q;
    assign mem_ready = mem_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboarded random + directed bench for ram_port_arbiter with an async SRAM model on a pulled-up bus.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [15:0] if_addr, mem_addr, mem_wdata;
    logic [15:0] if_rdata, mem_rdata, ram2_addr;
    logic        if_ready, mem_ready, busy, ram2_en_n, ram2_oe_n, ram2_we_n;
    wire  [15:0] ram2_data;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy),
        .ram2_addr(ram2_addr), .ram2_data(ram2_data),
        .ram2_en_n(ram2_en_n), .ram2_oe_n(ram2_oe_n), .ram2_we_n(ram2_we_n)
    );

    // Released bus reads as all ones; written data never uses FFFF.
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (ram2_data[i]);
    end

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'h1234 : (a ^ 16'h5A5A);
    endfunction

    // Asynchronous SRAM: drives while en/oe low, commits on the rising edge of we_n.
    logic [15:0] sram [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = init_val(16'(i));
        forever begin
            @(posedge ram2_we_n);
            if (!ram2_en_n) sram[ram2_addr] = ram2_data;
        end
    end
    assign ram2_data = (!ram2_en_n && !ram2_oe_n) ? sram[ram2_addr] : 16'hzzzz;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Reference model: word contents and the MEM port's visible read register.
    logic [15:0] ref_mem [0:65535];
    logic [15:0] mem_rdata_model = 16'h0000;

    typedef struct { logic [15:0] data; int due; } exp_t;
    exp_t if_exp[$];
    exp_t mem_exp[$];

    function automatic logic [19:0] pins();
        return {1'b0, ram2_en_n, ram2_oe_n, ram2_we_n, ram2_data};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            chk("oe_we_exclusive", {31'd0, !ram2_oe_n && !ram2_we_n}, 32'd0);
            if (ram2_en_n) chk("bus_released", {16'd0, ram2_data}, 32'h0000FFFF);
        end
        if (rst === 1'b0) begin
            if (if_ready) begin
                if (if_exp.size() == 0) begin
                    chk("if_ready_unexpected", 32'd1, 32'd0);
                end else begin
                    e = if_exp.pop_front();
                    chk("if_rdata", {16'd0, if_rdata}, {16'd0, e.data});
                    chk("if_latency", cyc, e.due);
                end
            end
            if (mem_ready) begin
                if (mem_exp.size() == 0) begin
                    chk("mem_ready_unexpected", 32'd1, 32'd0);
                end else begin
                    e = mem_exp.pop_front();
                    chk("mem_rdata", {16'd0, mem_rdata}, {16'd0, e.data});
                    chk("mem_latency", cyc, e.due);
                end
            end
        end
    end

    task automatic if_read(input logic [15:0] a, input int extra);
        bit got = 0;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = a;
        if_exp.push_back('{ref_mem[a], cyc + 3 + extra});
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (k == 0 && extra == 0) if_addr = 16'($urandom);
            got = if_ready;
        end
        if (!got) chk("if_timeout", 32'd0, 32'd1);
        if_req = 1'b0;
    endtask

    task automatic mem_op(input logic we, input logic [15:0] a, input logic [15:0] d);
        bit got = 0;
        bit io  = (a >= 16'hBF00) && (a <= 16'hBF03);
        int lat = io ? 1 : (we ? 4 : 3);
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d;
        if (!io && !we) mem_rdata_model = ref_mem[a];
        if (!io && we)  ref_mem[a] = d;
        mem_exp.push_back('{mem_rdata_model, cyc + lat});
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (k == 0) begin
                mem_addr  = 16'($urandom);
                mem_wdata = 16'($urandom);
            end
            got = mem_ready;
        end
        if (!got) chk("mem_timeout", 32'd0, 32'd1);
        mem_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
        rst = 1'b1;
        if_req = 0; mem_req = 0; mem_we = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_if_rdata",  {16'd0, if_rdata}, 32'd0);
        chk("rst_mem_rdata", {16'd0, mem_rdata}, 32'd0);
        chk("rst_ready_busy", {29'd0, if_ready, mem_ready, busy}, 32'd0);
        chk("rst_ram2_addr", {16'd0, ram2_addr}, 32'd0);
        chk("rst_pins", {12'd0, pins()}, {12'd0, 20'h7FFFF});
        rst = 1'b0;

        // IF read of 0x0010: strobes low in N+1..N+2, ready at N+3.
        fork
            if_read(16'h0010, 0);
            begin
                @(negedge clk);
                @(negedge clk); chk("ifrd_n1", {12'd0, pins()}, {12'd0, 4'b0001, 16'h1234});
                chk("ifrd_n1_addr", {16'd0, ram2_addr}, 32'h0010);
                @(negedge clk); chk("ifrd_n2", {12'd0, pins()}, {12'd0, 4'b0001, 16'h1234});
                @(negedge clk); chk("ifrd_n3", {12'd0, pins()}, {12'd0, 4'b0111, 16'hFFFF});
            end
        join

        // MEM write 0x0020 <- BEEF: bus driven N+1..N+3, we_n low only at N+2.
        fork
            mem_op(1'b1, 16'h0020, 16'hBEEF);
            begin
                @(negedge clk);
                @(negedge clk); chk("wr_n1", {12'd0, pins()}, {12'd0, 4'b0011, 16'hBEEF});
                @(negedge clk); chk("wr_n2", {12'd0, pins()}, {12'd0, 4'b0010, 16'hBEEF});
                @(negedge clk); chk("wr_n3", {12'd0, pins()}, {12'd0, 4'b0011, 16'hBEEF});
                @(negedge clk); chk("wr_n4", {12'd0, pins()}, {12'd0, 4'b0111, 16'hFFFF});
            end
        join
        mem_op(1'b0, 16'h0020, 16'h0000);

        // Simultaneous requests: MEM first, IF granted in the mem_ready cycle.
        fork
            mem_op(1'b0, 16'h0030, 16'h0000);
            if_read(16'h0040, 3);
        join

        // MMIO window: no strobes, ready next cycle, mem_rdata held.
        fork
            mem_op(1'b0, 16'hBF01, 16'h0000);
            begin
                @(negedge clk);
                @(negedge clk); chk("mmio_rd_pins", {12'd0, pins()}, {12'd0, 20'h7FFFF});
            end
        join
        fork
            mem_op(1'b1, 16'hBF00, 16'h1111);
            begin
                @(negedge clk);
                @(negedge clk); chk("mmio_wr_pins", {12'd0, pins()}, {12'd0, 20'h7FFFF});
                chk("mmio_busy", {31'd0, busy}, 32'd0);
            end
        join

        // Asynchronous reset during WR_PULSE.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'hA000; mem_wdata = 16'h1357;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_pulse_we", {31'd0, ram2_we_n}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("abort_pins", {12'd0, pins()}, {12'd0, 20'h7FFFF});
        chk("abort_ready_busy", {30'd0, mem_ready, busy}, 32'd0);
        mem_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_abort_busy", {31'd0, busy}, 32'd0);
        mem_rdata_model = 16'h0000;
        mem_op(1'b0, 16'h0020, 16'h0000);
        if_read(16'hBF02, 0);

        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            a = 16'($urandom_range(16'h0100, 16'h7FFF));
            case ($urandom_range(0, 4))
                0: if_read(a, 0);
                1: mem_op(1'b0, a, 16'h0000);
                2: mem_op(1'b1, a, 16'($urandom_range(0, 16'hFFFE)));
                3: mem_op(1'($urandom_range(0, 1)), 16'hBF00 + 16'($urandom_range(0, 3)),
                          16'($urandom_range(0, 16'hFFFE)));
                default: if_read(16'hBF00 + 16'($urandom_range(0, 3)), 0);
            endcase
        end

        repeat (5) @(negedge clk);
        chk("if_queue_drained", if_exp.size(), 32'd0);
        chk("mem_queue_drained", mem_exp.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
